// File: rtl/cpu_fetch_ctrl.sv
// cpu_fetch_ctrl: fetch PC sequencer, one outstanding imem request,
// 2-entry instruction buffer toward decode with redirect squash.
module cpu_fetch_ctrl #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            imem_resp_err,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [1:0]      instr_fault,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_DISCARD,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic [31:0]     word;
    logic [XLEN-1:0] pc;
    logic [1:0]      fault;
  } entry_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic            halt_pend;
  logic [1:0]      count;
  entry_t          e0;
  entry_t          e1;
  entry_t          push_e;
  entry_t          mis_e;

  logic req_fire;
  logic pop;
  logic push;
  logic mis;
  logic busy;

  // Slot reservation: only request while a free entry remains.
  assign imem_req_valid = rst_n && (state == ST_REQ)
                        && (count < 2'd2);
  assign imem_addr   = fetch_pc;
  assign req_fire    = imem_req_valid && imem_req_ready;
  assign instr_valid = count != 2'd0;
  assign pop         = instr_valid && instr_ready;
  assign push        = (state == ST_WAIT) && imem_resp_valid
                     && !redirect_valid;
  assign mis         = redirect_pc[1:0] != 2'b00;
  assign busy        = req_fire
                     || (((state == ST_WAIT)
                     || (state == ST_DISCARD))
                     && !imem_resp_valid);

  assign instr       = e0.word;
  assign instr_pc    = e0.pc;
  assign instr_fault = e0.fault;

  always_comb begin
    push_e       = '0;
    push_e.word  = imem_resp_err ? 32'd0 : imem_resp_data;
    push_e.pc    = fetch_pc - XLEN'(4);
    push_e.fault = imem_resp_err ? 2'b01 : 2'b00;
    mis_e        = '0;
    mis_e.pc     = redirect_pc;
    mis_e.fault  = 2'b10;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_REQ;
      fetch_pc  <= RESET_VECTOR;
      halt_pend <= 1'b0;
      count     <= 2'd0;
      e0        <= '0;
      e1        <= '0;
    end else if (redirect_valid) begin
      fetch_pc  <= redirect_pc;
      halt_pend <= mis;
      if (busy) begin
        state <= ST_DISCARD;
      end else if (mis) begin
        state <= ST_HALT;
      end else begin
        state <= ST_REQ;
      end
      // Misaligned target becomes a single fault entry.
      if (mis) begin
        e0    <= mis_e;
        count <= 2'd1;
      end else begin
        count <= 2'd0;
      end
    end else begin
      unique case (state)
        ST_REQ: begin
          if (req_fire) begin
            fetch_pc <= fetch_pc + XLEN'(4);
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            state <= imem_resp_err ? ST_HALT : ST_REQ;
          end
        end
        ST_DISCARD: begin
          if (imem_resp_valid) begin
            state <= halt_pend ? ST_HALT : ST_REQ;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
      endcase
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            e0 <= push_e;
          end else begin
            e1 <= push_e;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            e0 <= push_e;
          end else begin
            e0 <= e1;
            e1 <= push_e;
          end
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == 2'd2))
  );

endmodule

// File: tb/tb_cpu_fetch_ctrl.sv
// tb_cpu_fetch_ctrl: random memory/decode stimulus against a
// stream-level model of the expected fetch and decode sequences.
module tb_cpu_fetch_ctrl;
  localparam int          XLEN = 32;
  localparam logic [31:0] RV   = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        imem_resp_err = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [1:0]  instr_fault;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  cpu_fetch_ctrl #(.XLEN(XLEN), .RESET_VECTOR(RV)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .imem_resp_err(imem_resp_err),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .instr_fault(instr_fault),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int lat_min = 1;
  int lat_max = 1;
  int rdy_mode = 0;
  logic rq_rand = 1'b0;
  int err_mode = 0;
  logic [31:0] err_addr = '0;

  // Memory model: at most one pending response.
  logic        pend = 1'b0;
  logic        pend_stale = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  // Request stream and decode stream expectations.
  logic [31:0] exp_req_addr = RV;
  logic        req_stopped = 1'b0;
  logic [31:0] exp_dec_pc = RV;
  logic        dec_stopped = 1'b0;
  logic        dec_mis = 1'b0;

  int          pops = 0;
  int          fires = 0;
  logic [31:0] last_pc = '0;
  logic [31:0] last_instr = '0;
  logic [1:0]  last_fault = '0;
  logic [31:0] fire_log[$];

  function automatic logic [31:0] word_at(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  function automatic logic is_err(logic [31:0] a);
    if (err_mode == 1) return a == err_addr;
    if (err_mode == 2) return ((a >> 2) % 13) == 0;
    return 1'b0;
  endfunction

  task automatic cycle();
    logic fire, pop, rd, rsp, rerr, rst, ee;
    logic [31:0] rpc, e_i, e_pc, a;
    logic [1:0] e_f;
    #3;
    rst  = rst_n;
    fire = imem_req_valid && imem_req_ready;
    pop  = instr_valid && instr_ready;
    rd   = redirect_valid;
    rpc  = redirect_pc;
    rsp  = imem_resp_valid;
    rerr = imem_resp_err;
    a    = imem_addr;
    if (rst && req_stopped) begin
      checks++;
      if (imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL halt_idle: req_valid=%b addr=%h, required 0",
                 imem_req_valid, imem_addr);
      end
    end
    if (rst && pop) begin
      checks++;
      pops++;
      if (dec_stopped) begin
        errors++;
        $display("FAIL stream_extra: pc=%h seen, required none",
                 instr_pc);
      end else begin
        e_pc = exp_dec_pc;
        if (dec_mis) begin
          e_i = '0;
          e_f = 2'd2;
        end else begin
          ee  = is_err(e_pc);
          e_i = ee ? 32'd0 : word_at(e_pc);
          e_f = ee ? 2'd1 : 2'd0;
        end
        if (instr_pc !== e_pc || instr !== e_i
            || instr_fault !== e_f) begin
          errors++;
          $display("FAIL stream: pc=%h instr=%h fault=%0d, required pc=%h instr=%h fault=%0d",
                   instr_pc, instr, instr_fault, e_pc, e_i, e_f);
        end
        if (dec_mis || e_f != 2'd0) dec_stopped = 1'b1;
        else exp_dec_pc = exp_dec_pc + 32'd4;
      end
      last_pc    = instr_pc;
      last_instr = instr;
      last_fault = instr_fault;
    end
    if (rst && fire) begin
      checks++;
      fires++;
      fire_log.push_back(a);
      if (req_stopped || pend || a !== exp_req_addr) begin
        errors++;
        $display("FAIL request: addr=%h pend=%b halted=%b, required addr=%h none pending",
                 a, pend, req_stopped, exp_req_addr);
      end
      exp_req_addr = exp_req_addr + 32'd4;
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      pend = 1'b0;
      pend_stale = 1'b0;
      req_stopped = 1'b0;
      exp_req_addr = RV;
      exp_dec_pc = RV;
      dec_stopped = 1'b0;
      dec_mis = 1'b0;
    end else begin
      if (rsp) begin
        if (!pend_stale && !rd && rerr) req_stopped = 1'b1;
        pend = 1'b0;
      end
      if (fire) begin
        pend = 1'b1;
        pend_stale = 1'b0;
        pend_addr = a;
        pend_cnt = $urandom_range(lat_max, lat_min);
      end
      if (rd) begin
        if (pend) pend_stale = 1'b1;
        exp_req_addr = rpc;
        req_stopped = rpc[1:0] != 2'b00;
        exp_dec_pc = rpc;
        dec_mis = rpc[1:0] != 2'b00;
        dec_stopped = 1'b0;
      end
    end
    redirect_valid = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    imem_resp_err = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data = word_at(pend_addr);
        imem_resp_err = is_err(pend_addr);
      end
    end
    case (rdy_mode)
      0: instr_ready = 1'b1;
      1: instr_ready = $urandom_range(0, 2) != 0;
      default: instr_ready = 1'b0;
    endcase
    imem_req_ready = rq_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic wait_fire(input string nm);
    fire_log.delete();
    for (int i = 0; i < 30 && fire_log.size() == 0; i++) cycle();
    if (fire_log.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no request in 30 cycles, required one", nm);
    end
  endtask

  task automatic wait_pop(input string nm);
    int p0;
    p0 = pops;
    for (int i = 0; i < 30 && pops == p0; i++) cycle();
    if (pops == p0) begin
      checks++;
      errors++;
      $display("FAIL %s: no decode in 30 cycles, required one", nm);
    end
  endtask

  task automatic test_reset();
    int p0;
    err_mode = 0; lat_min = 1; lat_max = 1;
    rdy_mode = 0; rq_rand = 1'b0;
    rst_n = 1'b0;
    cycle();
    checks += 6;
    if (instr_valid !== 1'b0) begin errors++;
      $display("FAIL rst_valid: got %b, required 0", instr_valid); end
    if (imem_req_valid !== 1'b0) begin errors++;
      $display("FAIL rst_req: got %b, required 0", imem_req_valid); end
    if (instr !== 32'd0) begin errors++;
      $display("FAIL rst_instr: got %h, required 0", instr); end
    if (instr_pc !== 32'd0) begin errors++;
      $display("FAIL rst_pc: got %h, required 0", instr_pc); end
    if (instr_fault !== 2'd0) begin errors++;
      $display("FAIL rst_fault: got %0d, required 0", instr_fault); end
    if (imem_addr !== RV) begin errors++;
      $display("FAIL rst_addr: got %h, required %h", imem_addr, RV); end
    rst_n = 1'b1;
    fire_log.delete();
    p0 = pops;
    repeat (20) cycle();
    checks += 2;
    if (fire_log.size() < 3) begin
      errors++;
      $display("FAIL first_reqs: got %0d requests, required >=3",
               fire_log.size());
    end else if (fire_log[0] !== 32'h100 || fire_log[1] !== 32'h104
                 || fire_log[2] !== 32'h108) begin
      errors++;
      $display("FAIL first_reqs: got %h %h %h, required 100 104 108",
               fire_log[0], fire_log[1], fire_log[2]);
    end
    if (pops - p0 != 9) begin
      errors++;
      $display("FAIL throughput: got %0d in 20 cycles, required 9",
               pops - p0);
    end
  endtask

  task automatic test_stall();
    int f0, p0;
    rdy_mode = 2;
    instr_ready = 1'b0;
    do_reset();
    f0 = fires;
    repeat (10) cycle();
    checks += 3;
    if (fires - f0 != 2) begin errors++;
      $display("FAIL stall_fill: got %0d requests, required 2",
               fires - f0); end
    if (imem_req_valid !== 1'b0) begin errors++;
      $display("FAIL stall_req: got %b, required 0", imem_req_valid); end
    if (instr_valid !== 1'b1) begin errors++;
      $display("FAIL stall_valid: got %b, required 1", instr_valid); end
    rdy_mode = 0;
    instr_ready = 1'b1;
    p0 = pops;
    repeat (20) cycle();
    checks++;
    if (pops - p0 != 11) begin errors++;
      $display("FAIL stall_drain: got %0d in 20 cycles, required 11",
               pops - p0); end
  endtask

  task automatic test_redirect();
    logic found;
    lat_min = 3; lat_max = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      found = pend && !imem_resp_valid;
    end
    checks++;
    if (!found) begin errors++;
      $display("FAIL redir_setup: got no pending response, required one");
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    cycle();
    checks++;
    if (instr_valid !== 1'b0) begin errors++;
      $display("FAIL redir_flush: got valid=%b, required 0", instr_valid);
    end
    wait_fire("redir_req");
    checks++;
    if (fire_log.size() > 0 && fire_log[0] !== 32'h200) begin errors++;
      $display("FAIL redir_req: got %h, required 200", fire_log[0]); end
    wait_pop("redir_dec");
    checks++;
    if (last_pc !== 32'h200) begin errors++;
      $display("FAIL redir_dec: got pc %h, required 200", last_pc); end
  endtask

  task automatic test_misaligned();
    int f0;
    lat_min = 1; lat_max = 1;
    do_reset();
    repeat (5) cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h202;
    cycle();
    wait_pop("mis_entry");
    checks++;
    if (last_pc !== 32'h202 || last_fault !== 2'd2
        || last_instr !== 32'd0) begin errors++;
      $display("FAIL mis_entry: got pc=%h fault=%0d instr=%h, required 202 2 0",
               last_pc, last_fault, last_instr); end
    f0 = fires;
    repeat (8) cycle();
    checks += 2;
    if (fires != f0) begin errors++;
      $display("FAIL mis_idle: got %0d requests, required 0", fires - f0);
    end
    if (instr_valid !== 1'b0) begin errors++;
      $display("FAIL mis_empty: got valid=%b, required 0", instr_valid); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    cycle();
    wait_fire("mis_resume");
    checks++;
    if (fire_log.size() > 0 && fire_log[0] !== 32'h300) begin errors++;
      $display("FAIL mis_resume: got %h, required 300", fire_log[0]); end
    wait_pop("mis_dec");
    checks++;
    if (last_pc !== 32'h300) begin errors++;
      $display("FAIL mis_dec: got pc %h, required 300", last_pc); end
  endtask

  task automatic test_error();
    int p0;
    err_mode = 1;
    err_addr = 32'h10c;
    lat_min = 1; lat_max = 1;
    do_reset();
    p0 = pops;
    repeat (40) cycle();
    checks += 3;
    if (pops - p0 != 4) begin errors++;
      $display("FAIL err_count: got %0d entries, required 4", pops - p0);
    end
    if (last_pc !== 32'h10c || last_fault !== 2'd1
        || last_instr !== 32'd0) begin errors++;
      $display("FAIL err_entry: got pc=%h fault=%0d instr=%h, required 10c 1 0",
               last_pc, last_fault, last_instr); end
    if (imem_req_valid !== 1'b0) begin errors++;
      $display("FAIL err_halt: got req=%b, required 0", imem_req_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    cycle();
    wait_pop("err_restart");
    checks++;
    if (last_pc !== 32'h0) begin errors++;
      $display("FAIL err_restart: got pc %h, required 0", last_pc); end
  endtask

  task automatic test_reset_mid();
    logic found;
    err_mode = 0;
    lat_min = 4; lat_max = 4;
    rdy_mode = 2;
    instr_ready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      found = pend && instr_valid;
    end
    checks++;
    if (!found) begin errors++;
      $display("FAIL rmid_setup: got no wait with data, required one");
    end
    rst_n = 1'b0;
    cycle();
    checks += 2;
    if (instr_valid !== 1'b0) begin errors++;
      $display("FAIL rmid_valid: got %b, required 0", instr_valid); end
    if (imem_req_valid !== 1'b0) begin errors++;
      $display("FAIL rmid_req: got %b, required 0", imem_req_valid); end
    rst_n = 1'b1;
    rdy_mode = 0;
    instr_ready = 1'b1;
    wait_fire("rmid_restart");
    checks++;
    if (fire_log.size() > 0 && fire_log[0] !== RV) begin errors++;
      $display("FAIL rmid_restart: got %h, required %h", fire_log[0], RV);
    end
  endtask

  task automatic test_random();
    int p0, f0;
    logic [31:0] pc;
    err_mode = 2;
    lat_min = 1; lat_max = 4;
    rdy_mode = 1;
    rq_rand = 1'b1;
    do_reset();
    p0 = pops;
    f0 = fires;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        pc = $urandom_range(0, 1023) << 2;
        if ($urandom_range(0, 4) == 0) pc[1:0] = 2'($urandom_range(1, 3));
        redirect_valid = 1'b1;
        redirect_pc = pc;
      end
      cycle();
    end
    checks++;
    if (pops - p0 < 100 || fires - f0 < 100) begin errors++;
      $display("FAIL rand_progress: got %0d decodes %0d requests, required >=100 each",
               pops - p0, fires - f0); end
    rq_rand = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_stall();
    test_redirect();
    test_misaligned();
    test_error();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
